// File: rtl/sram_responder_pkg.sv
// CPU memory-map constants shared by the SRAM responder and its users.
package sram_responder_pkg;

    localparam logic [31:0]  SramBaseAddr   = 32'h1c00_0000;
    localparam int unsigned  SramDepthWords = 16384;
    localparam logic [31:0]  ResetPc        = 32'h1bff_fffc;

endpackage

// File: rtl/sram_byte_array.sv
// Word-organised RAM with per-byte write enables and a registered read-first port.
module sram_byte_array #(
    parameter int unsigned DEPTH_WORDS = 16384,
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            en_i,
    input  logic [3:0]      we_i,
    input  logic [IdxW-1:0] idx_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    // No reset on the array: contents survive a reset of the responder.
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[idx_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Single-port SRAM slave: range check, sticky error capture and read counter around the array.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = SramBaseAddr,
    parameter int unsigned DEPTH_WORDS = SramDepthWords
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic [31:0] rd_count
);

    localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] Base33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] Limit33 = Base33 + (33'(DEPTH_WORDS) << 2);

    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            accept;
    logic            arr_en;
    logic            oor;
    logic            rd;
    logic [31:0]     arr_rdata;

    logic        zero_q, zero_d;
    logic        err_flag_q, err_flag_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [31:0] rd_count_q, rd_count_d;

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign in_range = ({1'b0, sram_addr} >= Base33) && ({1'b0, sram_addr} < Limit33);
    assign idx      = IdxW'((sram_addr - BASE_ADDR) >> 2);
    assign accept   = resetn & sram_en;
    assign arr_en   = accept & in_range;
    assign oor      = accept & ~in_range;
    assign rd       = arr_en & (sram_we == 4'h0);

    sram_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .en_i    (arr_en),
        .we_i    (sram_we),
        .idx_i   (idx),
        .wdata_i (sram_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        zero_d     = zero_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        rd_count_d = rd_count_q;
        if (arr_en) begin
            zero_d = 1'b0;
        end
        if (oor) begin
            zero_d     = 1'b1;
            err_flag_d = 1'b1;
            if (!err_flag_q) begin
                err_addr_d = sram_addr;
            end
        end
        if (rd) begin
            rd_count_d = rd_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            zero_q     <= 1'b1;
            err_flag_q <= 1'b0;
            err_addr_q <= 32'h0;
            rd_count_q <= 32'h0;
        end else begin
            zero_q     <= zero_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
            rd_count_q <= rd_count_d;
        end
    end

    // The array register holds its last value; zero_q masks it after reset or a bad access.
    assign sram_rdata = zero_q ? 32'h0 : arr_rdata;
    assign err_flag   = err_flag_q;
    assign err_addr   = err_addr_q;
    assign rd_count   = rd_count_q;

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1c00_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 16384, array depth in 32-bit words, power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sram_en  input  1  request valid this cycle.
REQ-006 SHALL have port sram_we  input  4  byte write enables; 0 = read.
REQ-007 SHALL have port sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
REQ-009 SHALL have port sram_rdata  output  32  read data, registered.
REQ-010 SHALL have port err_flag  output  1  sticky out-of-range access flag.
REQ-011 SHALL have port err_addr  output  32  sram_addr of first out-of-range access.
REQ-012 SHALL have port rd_count  output  32  count of accepted in-range reads.

Function
REQ-013 SHALL decode index = (sram_addr - BASE_ADDR) >> 2; in-range iff BASE_ADDR <= sram_addr < BASE_ADDR + 4*DEPTH_WORDS, compared in 33-bit unsigned arithmetic so no wrap past 32'hffff_ffff.
REQ-014 SHALL, for sram_en=1, sram_we=0, in range: sram_rdata = mem[index] exactly one cycle after the request edge.
REQ-015 SHALL, for sram_en=1, sram_we!=0, in range: update only lanes with sram_we[i]=1 at that edge.
REQ-016 SHALL drive sram_rdata on a write to the pre-write word (read-first); same-address read next cycle returns the new data.
REQ-017 SHALL hold sram_rdata unchanged on any cycle with sram_en=0 (initiator may sample late under backpressure).
REQ-018 SHALL, for out-of-range sram_en=1: suppress the write, drive sram_rdata=32'h0 next cycle, set err_flag.
REQ-019 SHALL capture err_addr only on the first out-of-range access after reset; later ones leave it unchanged.
REQ-020 SHALL increment rd_count by 1 per in-range read, wrapping 32'hffff_ffff -> 0.
REQ-021 SHALL accept one request per cycle, back-to-back, no stall output; there is no ready signal.

Reset
REQ-022 SHALL, while resetn=0 at posedge: sram_rdata=0, err_flag=0, err_addr=0, rd_count=0.
REQ-023 SHALL ignore sram_en while resetn=0: no writes, no counting, no error capture.
REQ-024 SHALL NOT clear the memory array on reset; contents persist across reset mid-operation.
REQ-025 SHALL allow array preload by simulation-only file initialisation; no preload port.

Structure
REQ-026 SHALL take BASE_ADDR default and the reset PC (32'h1bff_fffc) from a shared package of CPU memory-map constants.
REQ-027 SHALL split out one sub-module, sram_byte_array (DEPTH_WORDS x 32, per-byte write, registered read-first port); range check, error and counter logic stay in the top.

Verification
REQ-028 SHALL cover: write 32'hdead_beef to 0x1c00_0000, we=4'hf, then read -> rdata 32'hdead_beef the cycle after the read.
REQ-029 SHALL cover: word 32'h1122_3344, write we=4'b0101 data 32'haabb_ccdd -> readback 32'h11bb_33dd.
REQ-030 SHALL cover: read 0x1c00_0004, then two en=0 cycles -> rdata holds the read value both cycles.
REQ-031 SHALL cover: read 0x1bff_fffc then 0x2000_0000 -> rdata 0 each, err_flag=1, err_addr=0x1bff_fffc, rd_count unchanged.
REQ-032 SHALL cover: 3 back-to-back reads, resetn=0 on the 2nd -> outputs zero, 3rd read counts as 1, array data intact.
REQ-033 SHALL cover: write then same-address read on consecutive cycles -> write-cycle rdata old value, read-cycle rdata new value.
